// File: rtl/fft_pkg.sv
// Shared types and defaults for the 16-point FFT front end.
package fft_pkg;

  localparam int DATA_W   = 16;
  localparam int N_POINTS = 16;
  localparam int IDX_W    = $clog2(N_POINTS);

  // One complex sample, two's-complement components.
  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

  // Identifies one of the two ping-pong banks.
  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;

  function automatic bank_e other_bank(input bank_e b);
    return (b == BANK_A) ? BANK_B : BANK_A;
  endfunction

endpackage

// File: rtl/fft_sample_bank.sv
// One N_POINTS-deep register bank of complex samples with a single
// indexed write port and every entry exposed on flat parallel buses.
// Component width comes from fft_pkg::cplx_t.
module fft_sample_bank
  import fft_pkg::*;
#(
  parameter int N_POINTS = fft_pkg::N_POINTS,
  parameter int AW       = $clog2(N_POINTS)
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [AW-1:0]                idx,
  input  cplx_t                        wdata,
  output logic [N_POINTS*DATA_W-1:0]   re,
  output logic [N_POINTS*DATA_W-1:0]   im
);

  cplx_t mem [N_POINTS];

  // Store the incoming sample at its frame position.
  // NOTE: sample storage has no reset; contents are only meaningful once a
  // full frame has been written, and leaving it unreset keeps it plain flops.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Sample k occupies bits [k*DATA_W +: DATA_W] of each bus.
  for (genvar k = 0; k < N_POINTS; k++) begin : g_flat
    assign re[k*DATA_W +: DATA_W] = mem[k].re;
    assign im[k*DATA_W +: DATA_W] = mem[k].im;
  end

endmodule

// File: rtl/fft16_input_buffer.sv
// Serial-to-parallel ping-pong buffer in front of the radix-4 butterfly.
// Samples fill bank[wr_bank]; a completed bank is held on the frame buses
// until the consumer takes it, while the other bank keeps filling.
// DATA_W overrides must match fft_pkg::DATA_W, which sizes cplx_t.
module fft16_input_buffer
  import fft_pkg::*;
#(
  parameter int DATA_W   = fft_pkg::DATA_W,
  parameter int N_POINTS = fft_pkg::N_POINTS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_re,
  input  logic [DATA_W-1:0]            in_im,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic [N_POINTS*DATA_W-1:0]   frame_re,
  output logic [N_POINTS*DATA_W-1:0]   frame_im,
  output logic [15:0]                  frame_cnt
);

  localparam int AW = $clog2(N_POINTS);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_POINTS - 1);

  bank_e          wr_bank;
  bank_e          rd_bank;
  logic [1:0]     full;
  logic [1:0]     full_next;
  logic [AW-1:0]  wr_idx;

  logic           wr_fire;
  logic           wr_last;
  logic           rd_fire;
  cplx_t          wdata;

  logic [N_POINTS*DATA_W-1:0] a_re, a_im, b_re, b_im;

  // Handshake decode. The write side only stalls when the bank it is
  // aiming at still holds an unreleased frame.
  assign in_ready    = !full[wr_bank] && !rst;
  assign frame_valid = full[rd_bank];
  assign wr_fire     = in_valid && in_ready;
  assign wr_last     = wr_fire && (wr_idx == LAST_IDX);
  assign rd_fire     = frame_valid && frame_ready;
  assign wdata       = '{re: in_re, im: in_im};

  // Next full flags: completion sets the write bank, release clears the
  // read bank. Both can happen together only on different banks.
  // NOTE: combinational blocks use blocking assignments and start from a
  // default so every path assigns full_next and no latch is inferred.
  always_comb begin
    full_next = full;
    if (wr_last) full_next[wr_bank] = 1'b1;
    if (rd_fire) full_next[rd_bank] = 1'b0;
  end

  // Pointer, flag and counter state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= BANK_A;
      rd_bank   <= BANK_A;
      full      <= 2'b00;
      wr_idx    <= '0;
      frame_cnt <= 16'd0;
    end else begin
      full <= full_next;
      if (wr_fire) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_last) begin
          wr_bank <= other_bank(wr_bank);
        end
      end
      if (rd_fire) begin
        rd_bank   <= other_bank(rd_bank);
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  fft_sample_bank #(.N_POINTS(N_POINTS)) u_bank_a (
    .clk   (clk),
    .we    (wr_fire && (wr_bank == BANK_A)),
    .idx   (wr_idx),
    .wdata (wdata),
    .re    (a_re),
    .im    (a_im)
  );

  fft_sample_bank #(.N_POINTS(N_POINTS)) u_bank_b (
    .clk   (clk),
    .we    (wr_fire && (wr_bank == BANK_B)),
    .idx   (wr_idx),
    .wdata (wdata),
    .re    (b_re),
    .im    (b_im)
  );

  // Present the bank currently owned by the consumer.
  always_comb begin
    frame_re = (rd_bank == BANK_B) ? b_re : a_re;
    frame_im = (rd_bank == BANK_B) ? b_im : a_im;
  end

endmodule

// File: tb/tb_fft16_input_buffer.sv
// Self-checking bench for fft16_input_buffer. A frame-level reference model
// (queues of accepted samples and completed frames) predicts the handshake,
// frame contents and frame count every cycle.
module tb_fft16_input_buffer;

  localparam int DW = 16;
  localparam int NP = 16;
  localparam int FW = DW * NP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_re = '0;
  logic [DW-1:0] in_im = '0;
  logic          frame_valid;
  logic          frame_ready = 1'b0;
  logic [FW-1:0] frame_re;
  logic [FW-1:0] frame_im;
  logic [15:0]   frame_cnt;

  fft16_input_buffer #(.DATA_W(DW), .N_POINTS(NP)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_re       (in_re),
    .in_im       (in_im),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_re    (frame_re),
    .frame_im    (frame_im),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [DW-1:0] part_re[$];
  logic [DW-1:0] part_im[$];
  logic [FW-1:0] q_re[$];
  logic [FW-1:0] q_im[$];
  logic [15:0]   exp_cnt = 16'd0;

  // Observations of the DUT.
  int            cyc = 0;
  int            obs_frames = 0;
  int            obs_acc = 0;
  int            obs_stalls = 0;
  logic [DW-1:0] obs_last_re0, obs_last_re15, obs_last_im15;
  int            pulse_cyc[$];

  typedef struct {
    string         name;
    int            n;
    bit            gap;
    int            base;
    int            exp_frames;
    logic [DW-1:0] exp_last_re0;
    logic [DW-1:0] exp_last_re15;
    logic [DW-1:0] exp_last_im15;
    int            exp_spacing;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    part_re.delete(); part_im.delete();
    q_re.delete(); q_im.delete();
    exp_cnt = 16'd0;
  endfunction

  // One clock cycle: compare outputs with the model, observe, advance.
  task automatic tick(output bit acc);
    bit            exp_ready, exp_valid, rel;
    logic [DW-1:0] cur_re, cur_im;
    logic [FW-1:0] fr, fi;
    #1;
    exp_ready = (q_re.size() < 2) && !rst;
    exp_valid = q_re.size() > 0;
    check("in_ready", in_ready, exp_ready);
    check("frame_valid", frame_valid, exp_valid);
    check("frame_cnt", frame_cnt, exp_cnt);
    if (exp_valid) begin
      check("frame_re", frame_re, q_re[0]);
      check("frame_im", frame_im, q_im[0]);
    end
    if (frame_valid && frame_ready) begin
      obs_frames++;
      obs_last_re0  = frame_re[0 +: DW];
      obs_last_re15 = frame_re[15*DW +: DW];
      obs_last_im15 = frame_im[15*DW +: DW];
      pulse_cyc.push_back(cyc);
    end
    if (in_valid && in_ready) obs_acc++;
    if (in_valid && !in_ready) obs_stalls++;
    acc = in_valid && exp_ready;
    rel = exp_valid && frame_ready;
    cur_re = in_re;
    cur_im = in_im;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (rel) begin
        void'(q_re.pop_front());
        void'(q_im.pop_front());
        exp_cnt++;
      end
      if (acc) begin
        part_re.push_back(cur_re);
        part_im.push_back(cur_im);
        if (part_re.size() == NP) begin
          for (int k = 0; k < NP; k++) begin
            fr[k*DW +: DW] = part_re[k];
            fi[k*DW +: DW] = part_im[k];
          end
          q_re.push_back(fr);
          q_im.push_back(fi);
          part_re.delete(); part_im.delete();
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input int v);
    in_valid = 1'b1;
    in_re    = DW'(v);
    in_im    = DW'(-v);
  endtask

  // Offer one sample and wait (bounded) until it is accepted.
  task automatic send_sample(input int v);
    bit acc;
    int budget;
    drive(v);
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 200) begin
      tick(acc);
      budget++;
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic do_reset();
    bit acc;
    rst = 1'b1;
    in_valid = 1'b0;
    frame_ready = 1'b0;
    tick(acc);
    rst = 1'b0;
    obs_frames = 0;
    obs_acc = 0;
    obs_stalls = 0;
    pulse_cyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    logic [FW-1:0] snap_re;

    vecs[0] = '{"basic_fill",   16, 1'b0, 0,     1, 16'h0000, 16'h000F, 16'hFFF1, 0};
    vecs[1] = '{"back_to_back", 64, 1'b0, 0,     4, 16'h0030, 16'h003F, 16'hFFC1, 16};
    vecs[2] = '{"gaps",         16, 1'b1, 'h200, 1, 16'h0200, 16'h020F, 16'hFDF1, 0};

    // Initial reset: DUT state is unknown until the first sampled reset.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    rst = 1'b0;
    #1;
    check("reset_frame_valid", frame_valid, 0);
    check("reset_frame_cnt", frame_cnt, 0);
    check("reset_in_ready", in_ready, 1);

    // Table-driven scenarios with frame_ready held high.
    foreach (vecs[i]) begin
      do_reset();
      frame_ready = 1'b1;
      for (int k = 0; k < vecs[i].n; k++) begin
        send_sample(vecs[i].base + k);
        if (vecs[i].gap) idle(1);
      end
      idle(3);
      check({vecs[i].name, "_frames"}, obs_frames, vecs[i].exp_frames);
      check({vecs[i].name, "_cnt"}, frame_cnt, vecs[i].exp_frames);
      check({vecs[i].name, "_stalls"}, obs_stalls, 0);
      check({vecs[i].name, "_re0"}, obs_last_re0, vecs[i].exp_last_re0);
      check({vecs[i].name, "_re15"}, obs_last_re15, vecs[i].exp_last_re15);
      check({vecs[i].name, "_im15"}, obs_last_im15, vecs[i].exp_last_im15);
      if (vecs[i].exp_spacing != 0)
        for (int p = 1; p < pulse_cyc.size(); p++)
          check({vecs[i].name, "_spacing"}, pulse_cyc[p] - pulse_cyc[p-1], vecs[i].exp_spacing);
    end

    // Backpressure: consumer stalled, source streams continuously.
    do_reset();
    frame_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      drive(obs_acc);
      tick(acc);
      if (c == 20) snap_re = frame_re;
    end
    check("bp_accepted", obs_acc, 32);
    check("bp_in_ready", in_ready, 0);
    check("bp_frame_valid", frame_valid, 1);
    check("bp_slice0", frame_re[0 +: DW], 16'd0);
    check("bp_stable", frame_re, snap_re);
    frame_ready = 1'b1;
    tick(acc);
    frame_ready = 1'b0;
    #1;
    check("bp_next_valid", frame_valid, 1);
    check("bp_next_slice0", frame_re[0 +: DW], 16'd16);
    check("bp_next_in_ready", in_ready, 1);
    check("bp_next_cnt", frame_cnt, 1);
    idle(2);

    // Release of frame A on the same edge as frame B's last sample.
    do_reset();
    frame_ready = 1'b0;
    for (int k = 0; k < 31; k++) send_sample(k);
    drive(31);
    frame_ready = 1'b1;
    tick(acc);
    check("sim_last_accepted", acc, 1);
    in_valid = 1'b0;
    #1;
    check("sim_b_valid", frame_valid, 1);
    check("sim_b_slice0", frame_re[0 +: DW], 16'd16);
    check("sim_b_slice15", frame_re[15*DW +: DW], 16'd31);
    check("sim_cnt1", frame_cnt, 1);
    tick(acc);
    #1;
    check("sim_empty", frame_valid, 0);
    check("sim_cnt2", frame_cnt, 2);
    idle(5);
    check("sim_no_dup", obs_frames, 2);
    frame_ready = 1'b0;

    // Reset in the middle of a partial frame.
    do_reset();
    frame_ready = 1'b1;
    for (int k = 0; k < 7; k++) send_sample('hAA + k);
    in_valid = 1'b0;
    rst = 1'b1;
    tick(acc);
    check("rst_valid_low", frame_valid, 0);
    rst = 1'b0;
    check("rst_cnt_zero", frame_cnt, 0);
    obs_frames = 0;
    for (int k = 0; k < 16; k++) send_sample('h100 + k);
    idle(2);
    check("rst_frames", obs_frames, 1);
    check("rst_slice0", obs_last_re0, 16'h0100);
    check("rst_slice15", obs_last_re15, 16'h010F);
    check("rst_cnt_one", frame_cnt, 1);

    // Randomised traffic against the model, with occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      in_re       = DW'($urandom);
      in_im       = DW'($urandom);
      frame_ready = $urandom_range(0, 1);
      rst         = ($urandom_range(0, 499) == 0);
      tick(acc);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    frame_ready = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
